sound_bus_sequencer: RTL and testbench
======================================

# sound_bus_sequencer

Sequences CPU accesses to the sound subsystem: POKEY register window and the 8-bit sound output latch. Generates the POKEY phi2 clock enable (3 MHz) and the 6 kHz amplifier tick from the system clock. Aligns each POKEY access to a phi2 period through a req/ack handshake. Sits between the CPU bus decode and the POKEY / audio output blocks in the sound top level.

## Interface
Parameters:
- DIV_3M, default 4: system clocks per `clk_3MHz_en` pulse; must be ≥2.
- DIV_6K, default 512: `clk_3MHz_en` pulses per `clk_6KHz_en` pulse; must be ≥2.

Ports:
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `mod_redbaron` in 1: selects the Red Baron address map; quasi-static.
- `req` in 1: CPU access request; held until `ack`.
- `we` in 1: 1 = write, 0 = read; sampled with `req` in IDLE.
- `addr` in 16: CPU address.
- `wdata` in 8: write data.
- `ack` out 1: one-cycle completion pulse.
- `rdata` out 8: read data; valid while `ack` = 1 and held afterwards.
- `clk_3MHz_en` out 1: phi2 enable pulse.
- `clk_6KHz_en` out 1: amplifier tick pulse.
- `pokey_cs` out 1: POKEY chip select, active-high; top level inverts it for `cs0Bar`.
- `pokey_we` out 1: POKEY write strobe qualifier.
- `pokey_a` out 4: POKEY register address.
- `pokey_din` out 8: POKEY write data.
- `pokey_dout` in 8: POKEY read data.
- `audiosel` out 1: output latch bit 0.
- `amp_sd` out 1: output latch bit 5.

## Operation
Address decode, registered in IDLE:
- POKEY window: 0x1820–0x182F when `mod_redbaron` = 0; 0x1810–0x181F when `mod_redbaron` = 1.
- Output latch: 0x1840 when `mod_redbaron` = 0; 0x1808 when `mod_redbaron` = 1.
- Anything else is unmapped.

States:
- IDLE: when `req` = 1, capture `addr`, `we` and `wdata`.
  - POKEY hit: go to SYNC.
  - Latch hit, write: latch ← `wdata`; go to ACK.
  - Latch hit, read: `rdata` ← latch; go to ACK.
  - Unmapped: `rdata` ← 0xFF, writes discarded; go to ACK.
- SYNC: wait for a `clk_3MHz_en` pulse. On the pulse, go to STROBE. `pokey_cs`, `pokey_a`, `pokey_we` and `pokey_din` become valid from the next cycle.
- STROBE: `pokey_cs` = 1 for exactly one full phi2 period. On the next `clk_3MHz_en` pulse:
  - read: `rdata` ← `pokey_dout`;
  - go to ACK; `pokey_cs` drops in the following cycle.
- ACK: `ack` = 1 for one cycle, then IDLE.

Handshake rules:
- `req` is examined only in IDLE.
- `req` held high through ACK starts a new transaction on the cycle after ACK.
- `req` dropped mid-transaction does not abort it.

Other rules:
- A `mod_redbaron` change takes effect only at the next IDLE capture.
- Reset at any time: return to IDLE and deassert `pokey_cs`. The latch clears, so `amp_sd` = 0 and the amplifier is enabled.

## Timing
- Reset values: `ack` 0, `rdata` 0x00, `clk_3MHz_en` 0, `clk_6KHz_en` 0, `pokey_cs` 0, `pokey_we` 0, `pokey_a` 0, `pokey_din` 0x00, latch 0x00, `audiosel` 0, `amp_sd` 0. Both dividers are 0.
- `clk_3MHz_en`: first pulse DIV_3M cycles after reset release, then every DIV_3M cycles; always one cycle wide.
- `clk_6KHz_en`: coincident with every DIV_6K-th `clk_3MHz_en` pulse. The first occurs on the DIV_6K-th pulse after reset.
- Latch or unmapped access: `req` captured at cycle t, `ack` at t+1.
- POKEY access latency:
  - SYNC waits 1..DIV_3M cycles;
  - STROBE lasts DIV_3M cycles;
  - ACK lasts 1 cycle.
- `ack` is never asserted in two consecutive cycles.
- All outputs are registered.

## Structure
- `sound_pkg` holds:
  - the address constants: BZ/RB POKEY base, BZ/RB latch address, window mask 0xFFF0;
  - the state enum `{IDLE, SYNC, STROBE, ACK}`;
  - the unmapped read value 0xFF.
- Sub-module `sound_clk_en_gen` (parameters DIV_3M, DIV_6K) contains both dividers and outputs the two enables. The FSM consumes `clk_3MHz_en` internally.

## Test plan
- Reset then free-run, DIV_3M=4, DIV_6K=512 → `clk_3MHz_en` pulses at cycles 4, 8, 12…; `clk_6KHz_en` first at cycle 2048, then every 2048 cycles.
- `mod_redbaron`=0, write 0x5A to 0x1823 → `pokey_cs` high for exactly 4 cycles starting the cycle after a phi2 pulse, with `pokey_a`=3, `pokey_din`=0x5A, `pokey_we`=1. `ack` pulses once.
- `mod_redbaron`=1, read 0x181A with `pokey_dout`=0xC3 → `pokey_a`=0xA, `rdata`=0xC3 at `ack`. An access to 0x1823 in the same mode returns 0xFF and leaves `pokey_cs` = 0.
- Write 0x21 to 0x1840 (BZ) → `ack` next cycle, `audiosel`=1, `amp_sd`=1. Read 0x1840 returns 0x21. Write to 0x1808 in BZ mode leaves the latch unchanged.
- `req` held high across two back-to-back latch writes → two `ack` pulses separated by at least one low cycle.
- Assert `rst` during STROBE → `pokey_cs` = 0 immediately, latch 0x00, no `ack`. The next request completes normally.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared constants, state encoding and address decode for the sound bus sequencer.
// Both the Bomb Zone and Red Baron address maps are described here.
package sound_pkg;

    localparam logic [15:0] BZ_POKEY_BASE  = 16'h1820;
    localparam logic [15:0] RB_POKEY_BASE  = 16'h1810;
    localparam logic [15:0] BZ_LATCH_ADDR  = 16'h1840;
    localparam logic [15:0] RB_LATCH_ADDR  = 16'h1808;
    localparam logic [15:0] POKEY_WIN_MASK = 16'hFFF0;
    localparam logic [7:0]  UNMAPPED_RDATA = 8'hFF;

    typedef enum logic [1:0] {IDLE, SYNC, STROBE, ACK} seq_state_t;

    typedef enum logic [1:0] {HIT_NONE, HIT_POKEY, HIT_LATCH} hit_t;

    // Classifies a CPU address against the currently selected board map.
    function automatic hit_t decode_addr(input logic [15:0] addr, input logic redbaron);
        logic [15:0] pokey_base;
        logic [15:0] latch_addr;
        pokey_base = redbaron ? RB_POKEY_BASE : BZ_POKEY_BASE;
        latch_addr = redbaron ? RB_LATCH_ADDR : BZ_LATCH_ADDR;
        if ((addr & POKEY_WIN_MASK) == pokey_base) begin
            return HIT_POKEY;
        end else if (addr == latch_addr) begin
            return HIT_LATCH;
        end
        return HIT_NONE;
    endfunction

endpackage

// File: rtl/sound_bus_sequencer_if.sv
// CPU-side request/acknowledge bus between the bus decode and the sound sequencer.
interface sound_bus_sequencer_if;

    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ack;
    logic [7:0]  rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/sound_clk_en_gen.sv
// Derives the POKEY phi2 enable and the amplifier tick from the system clock.
module sound_clk_en_gen #(
    parameter int DIV_3M = 4,
    parameter int DIV_6K = 512
) (
    input  logic clk,
    input  logic rst,
    output logic clk_3MHz_en,
    output logic clk_6KHz_en
);

    localparam int W3 = $clog2(DIV_3M);
    localparam int W6 = $clog2(DIV_6K);
    localparam logic [W3-1:0] LAST_3M = W3'(DIV_3M - 1);
    localparam logic [W6-1:0] LAST_6K = W6'(DIV_6K - 1);

    logic [W3-1:0] cnt_3m;
    logic [W6-1:0] cnt_6k;

    // The slow tick advances only on phi2 pulses so both enables stay coincident.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_3m      <= '0;
            cnt_6k      <= '0;
            clk_3MHz_en <= 1'b0;
            clk_6KHz_en <= 1'b0;
        end else if (cnt_3m == LAST_3M) begin
            cnt_3m      <= '0;
            clk_3MHz_en <= 1'b1;
            if (cnt_6k == LAST_6K) begin
                cnt_6k      <= '0;
                clk_6KHz_en <= 1'b1;
            end else begin
                cnt_6k      <= cnt_6k + 1'b1;
                clk_6KHz_en <= 1'b0;
            end
        end else begin
            cnt_3m      <= cnt_3m + 1'b1;
            clk_3MHz_en <= 1'b0;
            clk_6KHz_en <= 1'b0;
        end
    end

endmodule

// File: rtl/sound_bus_sequencer.sv
// Sequences CPU accesses into the POKEY window and the sound output latch,
// aligning POKEY cycles to one full phi2 period.
module sound_bus_sequencer
    import sound_pkg::*;
#(
    parameter int DIV_3M = 4,
    parameter int DIV_6K = 512
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mod_redbaron,
    sound_bus_sequencer_if.slave        bus,
    output logic                        clk_3MHz_en,
    output logic                        clk_6KHz_en,
    output logic                        pokey_cs,
    output logic                        pokey_we,
    output logic [3:0]                  pokey_a,
    output logic [7:0]                  pokey_din,
    input  logic [7:0]                  pokey_dout,
    output logic                        audiosel,
    output logic                        amp_sd
);

    seq_state_t state;
    seq_state_t next_state;
    hit_t       hit;

    logic       ack_q;
    logic [7:0] rdata_q;
    logic [7:0] out_latch;
    logic       cap_we;
    logic [3:0] cap_addr;
    logic [7:0] cap_wdata;

    sound_clk_en_gen #(
        .DIV_3M (DIV_3M),
        .DIV_6K (DIV_6K)
    ) u_clk_en_gen (
        .clk         (clk),
        .rst         (rst),
        .clk_3MHz_en (clk_3MHz_en),
        .clk_6KHz_en (clk_6KHz_en)
    );

    assign hit       = decode_addr(bus.addr, mod_redbaron);
    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign audiosel  = out_latch[0];
    assign amp_sd    = out_latch[5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    next_state = (hit == HIT_POKEY) ? SYNC : ACK;
                end
            end
            SYNC: begin
                if (clk_3MHz_en) begin
                    next_state = STROBE;
                end
            end
            STROBE: begin
                if (clk_3MHz_en) begin
                    next_state = ACK;
                end
            end
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ack and pokey_cs are registered copies of the upcoming state so they
    // line up exactly with the ACK and STROBE cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q     <= 1'b0;
            rdata_q   <= 8'h00;
            pokey_cs  <= 1'b0;
            pokey_we  <= 1'b0;
            pokey_a   <= 4'h0;
            pokey_din <= 8'h00;
            out_latch <= 8'h00;
            cap_we    <= 1'b0;
            cap_addr  <= 4'h0;
            cap_wdata <= 8'h00;
        end else begin
            ack_q    <= (next_state == ACK);
            pokey_cs <= (next_state == STROBE);
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        cap_we    <= bus.we;
                        cap_addr  <= bus.addr[3:0];
                        cap_wdata <= bus.wdata;
                        case (hit)
                            HIT_LATCH: begin
                                if (bus.we) begin
                                    out_latch <= bus.wdata;
                                end else begin
                                    rdata_q <= out_latch;
                                end
                            end
                            HIT_POKEY: begin
                            end
                            default: rdata_q <= UNMAPPED_RDATA;
                        endcase
                    end
                end
                SYNC: begin
                    if (clk_3MHz_en) begin
                        pokey_a   <= cap_addr;
                        pokey_we  <= cap_we;
                        pokey_din <= cap_wdata;
                    end
                end
                STROBE: begin
                    if (clk_3MHz_en) begin
                        if (!cap_we) begin
                            rdata_q <= pokey_dout;
                        end
                        pokey_we <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sound_bus_sequencer.sv
// Directed self-checking bench for sound_bus_sequencer with hand-computed expectations.
module tb_sound_bus_sequencer;

    logic       clk;
    logic       rst;
    logic       mod_redbaron;
    logic       clk_3MHz_en;
    logic       clk_6KHz_en;
    logic       pokey_cs;
    logic       pokey_we;
    logic [3:0] pokey_a;
    logic [7:0] pokey_din;
    logic [7:0] pokey_dout;
    logic       audiosel;
    logic       amp_sd;

    int tests;
    int failures;

    int         res_cs_cycles;
    int         res_acks;
    int         res_ack_lat;
    logic       res_cs_after_pulse;
    logic [3:0] res_pa;
    logic       res_pw;
    logic [7:0] res_pd;
    logic [7:0] res_rd;

    sound_bus_sequencer_if bus ();

    sound_bus_sequencer #(
        .DIV_3M (4),
        .DIV_6K (512)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mod_redbaron (mod_redbaron),
        .bus          (bus),
        .clk_3MHz_en  (clk_3MHz_en),
        .clk_6KHz_en  (clk_6KHz_en),
        .pokey_cs     (pokey_cs),
        .pokey_we     (pokey_we),
        .pokey_a      (pokey_a),
        .pokey_din    (pokey_din),
        .pokey_dout   (pokey_dout),
        .audiosel     (audiosel),
        .amp_sd       (amp_sd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one bus transaction from a falling edge and records what the POKEY side and CPU side saw.
    task automatic applyStimulus(input logic w, input logic [15:0] a, input logic [7:0] d);
        logic prev_en3;
        logic done;
        res_cs_cycles      = 0;
        res_acks           = 0;
        res_ack_lat        = 0;
        res_cs_after_pulse = 1'b0;
        res_pa             = 4'h0;
        res_pw             = 1'b0;
        res_pd             = 8'h00;
        res_rd             = 8'h00;
        prev_en3           = 1'b0;
        done               = 1'b0;
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        for (int n = 1; n <= 40 && !done; n++) begin
            @(negedge clk);
            if (pokey_cs) begin
                if (res_cs_cycles == 0) begin
                    res_cs_after_pulse = prev_en3;
                    res_pa             = pokey_a;
                    res_pw             = pokey_we;
                    res_pd             = pokey_din;
                end
                res_cs_cycles++;
            end
            prev_en3 = clk_3MHz_en;
            if (bus.ack) begin
                res_acks++;
                res_ack_lat = n;
                res_rd      = bus.rdata;
                bus.req     = 1'b0;
                done        = 1'b1;
            end
        end
        bus.req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.ack)  res_acks++;
            if (pokey_cs) res_cs_cycles++;
        end
    endtask

    initial begin
        int hits;
        tests        = 0;
        failures     = 0;
        rst          = 1'b1;
        mod_redbaron = 1'b0;
        pokey_dout   = 8'h00;
        bus.req      = 1'b0;
        bus.we       = 1'b0;
        bus.addr     = 16'h0000;
        bus.wdata    = 8'h00;

        repeat (3) @(negedge clk);
        checkOutput("reset_ack",      32'(bus.ack),     32'h0);
        checkOutput("reset_rdata",    32'(bus.rdata),   32'h00);
        checkOutput("reset_en3",      32'(clk_3MHz_en), 32'h0);
        checkOutput("reset_en6",      32'(clk_6KHz_en), 32'h0);
        checkOutput("reset_cs",       32'(pokey_cs),    32'h0);
        checkOutput("reset_pokey_we", 32'(pokey_we),    32'h0);
        checkOutput("reset_pokey_a",  32'(pokey_a),     32'h0);
        checkOutput("reset_din",      32'(pokey_din),   32'h00);
        checkOutput("reset_audiosel", 32'(audiosel),    32'h0);
        checkOutput("reset_amp_sd",   32'(amp_sd),      32'h0);
        rst = 1'b0;

        for (int c = 1; c <= 4100; c++) begin
            @(negedge clk);
            checkOutput($sformatf("en3_cycle%0d", c), 32'(clk_3MHz_en), 32'((c % 4) == 0));
            checkOutput($sformatf("en6_cycle%0d", c), 32'(clk_6KHz_en), 32'((c % 2048) == 0));
        end

        applyStimulus(1'b1, 16'h1823, 8'h5A);
        checkOutput("bz_wr_cs_len",     32'(res_cs_cycles),      32'd4);
        checkOutput("bz_wr_after_pulse", 32'(res_cs_after_pulse), 32'h1);
        checkOutput("bz_wr_pokey_a",    32'(res_pa),             32'h3);
        checkOutput("bz_wr_pokey_we",   32'(res_pw),             32'h1);
        checkOutput("bz_wr_pokey_din",  32'(res_pd),             32'h5A);
        checkOutput("bz_wr_acks",       32'(res_acks),           32'd1);

        mod_redbaron = 1'b1;
        pokey_dout   = 8'hC3;
        applyStimulus(1'b0, 16'h181A, 8'h00);
        checkOutput("rb_rd_pokey_a",  32'(res_pa),        32'hA);
        checkOutput("rb_rd_pokey_we", 32'(res_pw),        32'h0);
        checkOutput("rb_rd_rdata",    32'(res_rd),        32'hC3);
        checkOutput("rb_rd_cs_len",   32'(res_cs_cycles), 32'd4);
        checkOutput("rb_rd_acks",     32'(res_acks),      32'd1);

        applyStimulus(1'b0, 16'h1823, 8'h00);
        checkOutput("rb_unmap_rdata", 32'(res_rd),        32'hFF);
        checkOutput("rb_unmap_cs",    32'(res_cs_cycles), 32'd0);
        checkOutput("rb_unmap_lat",   32'(res_ack_lat),   32'd1);

        applyStimulus(1'b1, 16'h1808, 8'h01);
        checkOutput("rb_latch_lat",      32'(res_ack_lat), 32'd1);
        checkOutput("rb_latch_audiosel", 32'(audiosel),    32'h1);
        checkOutput("rb_latch_amp_sd",   32'(amp_sd),      32'h0);

        mod_redbaron = 1'b0;
        applyStimulus(1'b1, 16'h1840, 8'h21);
        checkOutput("bz_latch_lat",      32'(res_ack_lat), 32'd1);
        checkOutput("bz_latch_audiosel", 32'(audiosel),    32'h1);
        checkOutput("bz_latch_amp_sd",   32'(amp_sd),      32'h1);

        applyStimulus(1'b0, 16'h1840, 8'h00);
        checkOutput("bz_latch_rd", 32'(res_rd), 32'h21);

        applyStimulus(1'b1, 16'h1808, 8'h00);
        checkOutput("bz_1808_acks",     32'(res_acks), 32'd1);
        checkOutput("bz_1808_audiosel", 32'(audiosel), 32'h1);
        checkOutput("bz_1808_amp_sd",   32'(amp_sd),   32'h1);

        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 16'h1840;
        bus.wdata = 8'h01;
        @(negedge clk);
        checkOutput("b2b_ack1", 32'(bus.ack), 32'h1);
        bus.wdata = 8'h20;
        @(negedge clk);
        checkOutput("b2b_gap",      32'(bus.ack),  32'h0);
        checkOutput("b2b_first_wr", 32'(audiosel), 32'h1);
        @(negedge clk);
        checkOutput("b2b_ack2", 32'(bus.ack), 32'h1);
        bus.req = 1'b0;
        @(negedge clk);
        checkOutput("b2b_after",    32'(bus.ack),  32'h0);
        checkOutput("b2b_audiosel", 32'(audiosel), 32'h0);
        checkOutput("b2b_amp_sd",   32'(amp_sd),   32'h1);

        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 16'h1825;
        bus.wdata = 8'h77;
        hits = 0;
        for (int n = 0; n < 20 && hits == 0; n++) begin
            @(negedge clk);
            if (pokey_cs) hits = 1;
        end
        checkOutput("rst_reached_strobe", 32'(hits), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_cs",       32'(pokey_cs), 32'h0);
        checkOutput("rst_audiosel", 32'(audiosel), 32'h0);
        checkOutput("rst_amp_sd",   32'(amp_sd),   32'h0);
        checkOutput("rst_ack",      32'(bus.ack),  32'h0);
        checkOutput("rst_rdata",    32'(bus.rdata), 32'h00);
        bus.req = 1'b0;
        hits = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (bus.ack) hits++;
        end
        checkOutput("rst_no_ack", 32'(hits), 32'd0);
        rst = 1'b0;

        applyStimulus(1'b0, 16'h1840, 8'h00);
        checkOutput("post_rst_latch_rd", 32'(res_rd),   32'h00);
        checkOutput("post_rst_latch_ack", 32'(res_acks), 32'd1);

        pokey_dout = 8'h3C;
        applyStimulus(1'b0, 16'h182F, 8'h00);
        checkOutput("post_rst_pokey_a", 32'(res_pa),        32'hF);
        checkOutput("post_rst_rdata",   32'(res_rd),        32'h3C);
        checkOutput("post_rst_cs_len",  32'(res_cs_cycles), 32'd4);
        checkOutput("post_rst_acks",    32'(res_acks),      32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
